// File: rtl/issue_scoreboard_if.sv
// Decode / issue / writeback signal bundle for issue_scoreboard.
// The master side is the surrounding pipeline (decoder, execute, writeback);
// the slave side is the scoreboard itself.
interface issue_scoreboard_if;
  // decoder -> scoreboard
  logic       dec_valid;
  logic       dec_ready;
  logic [6:0] dec_opcode;
  logic [4:0] dec_rd;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  // scoreboard -> execute
  logic       iss_valid;
  logic       iss_ready;
  logic [6:0] iss_opcode;
  logic [4:0] iss_rd;
  logic [4:0] iss_rs1;
  logic [4:0] iss_rs2;
  // writeback -> scoreboard
  logic       wb_valid;
  logic [4:0] wb_rd;

  modport master (
    output dec_valid, dec_opcode, dec_rd, dec_rs1, dec_rs2,
    input  dec_ready,
    input  iss_valid, iss_opcode, iss_rd, iss_rs1, iss_rs2,
    output iss_ready,
    output wb_valid, wb_rd
  );

  modport slave (
    input  dec_valid, dec_opcode, dec_rd, dec_rs1, dec_rs2,
    output dec_ready,
    output iss_valid, iss_opcode, iss_rd, iss_rs1, iss_rs2,
    input  iss_ready,
    input  wb_valid, wb_rd
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Register scoreboard plus single-entry issue slot between decode and execute.
// Stalls decode on RAW/WAW hazards against in-flight writers, drains the pipe
// before FENCE/SYSTEM, clears busy bits on writeback and empties on flush.
module issue_scoreboard #(
  parameter int NREG    = 32,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  issue_scoreboard_if.slave  bus,
  output logic [NREG-1:0]    busy,
  output logic               drain_st,
  output logic [STALL_W-1:0] stall_cnt
);

  // RISC-V major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_MEM    = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  function automatic logic f_uses_rs1(input logic [6:0] op);
    return op inside {OP_OP, OP_IMM, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE};
  endfunction

  function automatic logic f_uses_rs2(input logic [6:0] op);
    return op inside {OP_OP, OP_BRANCH, OP_STORE};
  endfunction

  function automatic logic f_writes_rd(input logic [6:0] op);
    return op inside {OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD};
  endfunction

  logic [0:0]         state_q, state_d;
  logic [NREG-1:0]    busy_q, busy_d;
  logic               iss_valid_q, iss_valid_d;
  logic [6:0]         iss_opcode_q, iss_opcode_d;
  logic [4:0]         iss_rd_q, iss_rd_d;
  logic [4:0]         iss_rs1_q, iss_rs1_d;
  logic [4:0]         iss_rs2_q, iss_rs2_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [NREG-1:0] eff_busy;
  logic            dec_uses_rs1, dec_uses_rs2, dec_writes_rd;
  logic            hazard, slot_free, drain_ok, is_drain_op;
  logic            dec_ready, accept;

  // Decode classification and hazard detection with same-cycle writeback bypass
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    eff_busy = busy_q;
    if (bus.wb_valid) eff_busy[bus.wb_rd] = 1'b0;
    dec_uses_rs1  = f_uses_rs1(bus.dec_opcode) && (bus.dec_rs1 != 5'd0);
    dec_uses_rs2  = f_uses_rs2(bus.dec_opcode) && (bus.dec_rs2 != 5'd0);
    dec_writes_rd = f_writes_rd(bus.dec_opcode) && (bus.dec_rd != 5'd0);
    hazard = (dec_uses_rs1  && eff_busy[bus.dec_rs1]) ||
             (dec_uses_rs2  && eff_busy[bus.dec_rs2]) ||
             (dec_writes_rd && eff_busy[bus.dec_rd]);
    slot_free   = !iss_valid_q || bus.iss_ready;
    drain_ok    = (eff_busy == '0) && slot_free;
    is_drain_op = (bus.dec_opcode == OP_MEM) || (bus.dec_opcode == OP_SYS);
  end

  // RUN/DRAIN control: decides dec_ready and the next FSM state
  always_comb begin
    state_d   = state_q;
    dec_ready = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (flush) begin
          dec_ready = 1'b0;
        end else if (bus.dec_valid && is_drain_op) begin
          state_d = ST_DRAIN;
        end else begin
          dec_ready = slot_free && !hazard;
        end
      end
      ST_DRAIN: begin
        if (flush) begin
          state_d = ST_RUN;
        end else if (drain_ok) begin
          // the fence/system instruction itself carries no register dependencies
          dec_ready = 1'b1;
          if (bus.dec_valid) state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    accept = bus.dec_valid && dec_ready;
  end

  // Issue slot: load on accept, hold while stalled, empty on take or flush
  always_comb begin
    iss_valid_d  = iss_valid_q;
    iss_opcode_d = iss_opcode_q;
    iss_rd_d     = iss_rd_q;
    iss_rs1_d    = iss_rs1_q;
    iss_rs2_d    = iss_rs2_q;
    if (accept) begin
      iss_valid_d  = 1'b1;
      iss_opcode_d = bus.dec_opcode;
      iss_rd_d     = bus.dec_rd;
      iss_rs1_d    = bus.dec_rs1;
      iss_rs2_d    = bus.dec_rs2;
    end else if (flush || bus.iss_ready) begin
      iss_valid_d = 1'b0;
    end
  end

  // Busy vector: writeback clears, killed slot writer clears, accept sets (set wins)
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_valid) busy_d[bus.wb_rd] = 1'b0;
    if (flush && iss_valid_q && !bus.iss_ready && f_writes_rd(iss_opcode_q))
      busy_d[iss_rd_q] = 1'b0;
    if (accept && dec_writes_rd) busy_d[bus.dec_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Saturating count of cycles where decode offered an instruction and was refused
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.dec_valid && !dec_ready && !flush && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the busy vector is plain flops, not a memory, so it is fully reset here.
      state_q      <= ST_RUN;
      busy_q       <= '0;
      iss_valid_q  <= 1'b0;
      iss_opcode_q <= '0;
      iss_rd_q     <= '0;
      iss_rs1_q    <= '0;
      iss_rs2_q    <= '0;
      stall_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      busy_q       <= busy_d;
      iss_valid_q  <= iss_valid_d;
      iss_opcode_q <= iss_opcode_d;
      iss_rd_q     <= iss_rd_d;
      iss_rs1_q    <= iss_rs1_d;
      iss_rs2_q    <= iss_rs2_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.dec_ready  = dec_ready;
  assign bus.iss_valid  = iss_valid_q;
  assign bus.iss_opcode = iss_opcode_q;
  assign bus.iss_rd     = iss_rd_q;
  assign bus.iss_rs1    = iss_rs1_q;
  assign bus.iss_rs2    = iss_rs2_q;
  assign busy           = busy_q;
  assign drain_st       = (state_q == ST_DRAIN);
  assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: expected issue-slot contents are queued
// when an accept is expected and compared when execute takes the slot.
module tb_issue_scoreboard;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_MEM   = 7'b0001111;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef struct packed {
    logic [6:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ins_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] busy;
  logic        drain_st;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;
  ins_t exp_q[$];
  ins_t mon_e;
  ins_t drop;

  issue_scoreboard_if bus ();

  issue_scoreboard #(.NREG(32), .STALL_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .busy      (busy),
    .drain_st  (drain_st),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic dec(input logic v, input logic [6:0] op, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2);
    bus.dec_valid  = v;
    bus.dec_opcode = op;
    bus.dec_rd     = rd;
    bus.dec_rs1    = rs1;
    bus.dec_rs2    = rs2;
  endtask

  task automatic push(input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2);
    exp_q.push_back({op, rd, rs1, rs2});
  endtask

  task automatic wb(input logic v, input logic [4:0] rd);
    bus.wb_valid = v;
    bus.wb_rd    = rd;
  endtask

  // Compare slot contents against the scoreboard whenever execute takes it
  always @(posedge clk) begin
    if (rst_n && bus.iss_valid && bus.iss_ready) begin
      check("iss_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("iss_fields", 32'({bus.iss_opcode, bus.iss_rd, bus.iss_rs1, bus.iss_rs2}),
              32'(mon_e));
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.iss_ready = 1'b1;
    dec(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    wb(1'b0, 5'd0);
    #3;
    check("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_drain", 32'(drain_st), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    #9;
    rst_n = 1'b1;
    tick();

    // 1: RAW stall on x5, released by same-cycle writeback
    dec(1'b1, OP_OP, 5'd5, 5'd1, 5'd2);
    settle();
    check("t1_ready_add5", 32'(bus.dec_ready), 32'd1);
    push(OP_OP, 5'd5, 5'd1, 5'd2);
    tick();
    check("t1_iss_valid", 32'(bus.iss_valid), 32'd1);
    check("t1_iss_rd5", 32'(bus.iss_rd), 32'd5);
    check("t1_busy5", busy, 32'h0000_0020);
    dec(1'b1, OP_OP, 5'd6, 5'd5, 5'd1);
    settle();
    check("t1_raw_stall", 32'(bus.dec_ready), 32'd0);
    tick();
    check("t1_still_stall", 32'(bus.dec_ready), 32'd0);
    check("t1_slot_empty", 32'(bus.iss_valid), 32'd0);
    wb(1'b1, 5'd5);
    settle();
    check("t1_wb_bypass", 32'(bus.dec_ready), 32'd1);
    push(OP_OP, 5'd6, 5'd5, 5'd1);
    tick();
    check("t1_iss_rd6", 32'(bus.iss_rd), 32'd6);
    check("t1_busy6", busy, 32'h0000_0040);
    check("t1_stall_cnt", 32'(stall_cnt), 32'd1);
    dec(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    wb(1'b1, 5'd6);
    tick();
    wb(1'b0, 5'd0);
    check("t1_busy_clear", busy, 32'd0);

    // 2: x0 never becomes busy
    dec(1'b1, OP_LUI, 5'd0, 5'd0, 5'd0);
    settle();
    check("t2_ready_lui", 32'(bus.dec_ready), 32'd1);
    push(OP_LUI, 5'd0, 5'd0, 5'd0);
    tick();
    check("t2_busy_x0", busy, 32'd0);
    dec(1'b1, OP_OP, 5'd1, 5'd0, 5'd0);
    settle();
    check("t2_ready_add", 32'(bus.dec_ready), 32'd1);
    push(OP_OP, 5'd1, 5'd0, 5'd0);
    tick();
    check("t2_busy_x1", busy, 32'h0000_0002);
    check("t2_no_stall", 32'(stall_cnt), 32'd1);
    dec(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    wb(1'b1, 5'd1);
    tick();
    wb(1'b0, 5'd0);
    check("t2_busy_clear", busy, 32'd0);

    // 3: execute back-pressure holds the slot for 3 cycles
    bus.iss_ready = 1'b0;
    dec(1'b1, OP_OP, 5'd10, 5'd0, 5'd0);
    settle();
    check("t3_ready_x10", 32'(bus.dec_ready), 32'd1);
    push(OP_OP, 5'd10, 5'd0, 5'd0);
    tick();
    check("t3_iss_rd10", 32'(bus.iss_rd), 32'd10);
    dec(1'b1, OP_OP, 5'd11, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t3_hold_ready", 32'(bus.dec_ready), 32'd0);
      check("t3_hold_slot", 32'({bus.iss_valid, bus.iss_opcode, bus.iss_rd}),
            32'({1'b1, OP_OP, 5'd10}));
      tick();
    end
    check("t3_stall_cnt", 32'(stall_cnt), 32'd4);
    bus.iss_ready = 1'b1;
    settle();
    check("t3_ready_x11", 32'(bus.dec_ready), 32'd1);
    push(OP_OP, 5'd11, 5'd0, 5'd0);
    tick();
    check("t3_iss_rd11", 32'(bus.iss_rd), 32'd11);
    dec(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    wb(1'b1, 5'd10);
    tick();
    wb(1'b1, 5'd11);
    tick();
    wb(1'b0, 5'd0);
    check("t3_busy_clear", busy, 32'd0);

    // 4: FENCE drains behind an in-flight LOAD x7
    dec(1'b1, OP_LOAD, 5'd7, 5'd2, 5'd0);
    settle();
    check("t4_ready_load", 32'(bus.dec_ready), 32'd1);
    push(OP_LOAD, 5'd7, 5'd2, 5'd0);
    tick();
    check("t4_busy7", busy, 32'h0000_0080);
    dec(1'b1, OP_MEM, 5'd0, 5'd0, 5'd0);
    settle();
    check("t4_fence_refused", 32'(bus.dec_ready), 32'd0);
    check("t4_not_drain_yet", 32'(drain_st), 32'd0);
    tick();
    check("t4_drain1", 32'(drain_st), 32'd1);
    check("t4_drain1_ready", 32'(bus.dec_ready), 32'd0);
    tick();
    check("t4_drain2", 32'(drain_st), 32'd1);
    check("t4_drain2_ready", 32'(bus.dec_ready), 32'd0);
    wb(1'b1, 5'd7);
    settle();
    check("t4_fence_ready", 32'(bus.dec_ready), 32'd1);
    push(OP_MEM, 5'd0, 5'd0, 5'd0);
    tick();
    wb(1'b0, 5'd0);
    dec(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    check("t4_back_run", 32'(drain_st), 32'd0);
    check("t4_fence_issued", 32'({bus.iss_valid, bus.iss_opcode}), 32'({1'b1, OP_MEM}));
    check("t4_busy_clear", busy, 32'd0);
    check("t4_stall_cnt", 32'(stall_cnt), 32'd6);
    tick();

    // 5: flush kills a held ADD x9 and its busy bit
    bus.iss_ready = 1'b0;
    dec(1'b1, OP_OP, 5'd9, 5'd0, 5'd0);
    settle();
    check("t5_ready_x9", 32'(bus.dec_ready), 32'd1);
    push(OP_OP, 5'd9, 5'd0, 5'd0);
    tick();
    check("t5_busy9", busy, 32'h0000_0200);
    flush = 1'b1;
    dec(1'b1, OP_OP, 5'd12, 5'd0, 5'd0);
    settle();
    check("t5_flush_ready", 32'(bus.dec_ready), 32'd0);
    tick();
    flush = 1'b0;
    dec(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    drop = exp_q.pop_front();
    check("t5_iss_valid", 32'(bus.iss_valid), 32'd0);
    check("t5_busy_clear", busy, 32'd0);
    check("t5_stall_cnt", 32'(stall_cnt), 32'd6);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // 6: saturate the stall counter, then reset asynchronously mid-stall
    bus.iss_ready = 1'b1;
    dec(1'b1, OP_OP, 5'd13, 5'd0, 5'd0);
    settle();
    check("t6_ready_x13", 32'(bus.dec_ready), 32'd1);
    push(OP_OP, 5'd13, 5'd0, 5'd0);
    tick();
    bus.iss_ready = 1'b0;
    dec(1'b1, OP_OP, 5'd14, 5'd0, 5'd0);
    repeat (65536) tick();
    check("t6_stall_sat", 32'(stall_cnt), 32'h0000_FFFF);
    repeat (2) tick();
    check("t6_stall_hold", 32'(stall_cnt), 32'h0000_FFFF);
    check("t6_busy13", busy, 32'h0000_2000);
    settle();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t6_rst_iss_valid", 32'(bus.iss_valid), 32'd0);
    check("t6_rst_iss_fields", 32'({bus.iss_opcode, bus.iss_rd, bus.iss_rs1, bus.iss_rs2}),
          32'd0);
    check("t6_rst_busy", busy, 32'd0);
    check("t6_rst_drain", 32'(drain_st), 32'd0);
    check("t6_rst_stall", 32'(stall_cnt), 32'd0);
    dec(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
